ir_keypad_tx: RTL and testbench

Parametrised keypad-to-infrared transmitter: debounces N keys, maps the winning key to a 32-bit code from a per-key table, and emits a carrier-modulated NEC- or Samsung-format frame. While the key is held it auto-repeats at the protocol frame period. It sits between board keys and the IR LED GPIO, replacing the fixed two-command arrangement with a generic N-key, two-protocol transmitter.

---
 rtl/ir_pkg.sv | 35 +++
 rtl/ir_debounce.sv | 54 +++++
 rtl/ir_keypad_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_ir_keypad_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the keypad-to-IR transmitter.
// Contents:
//   ir_state_e    - transmitter FSM states
//   MODE_*        - protocol selection values for the MODE parameter
//   T_*           - state durations in protocol units T
//   is_mark()     - true for states that drive the IR envelope high
package ir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StRptSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } ir_state_e;

  localparam int unsigned MODE_NEC     = 0;
  localparam int unsigned MODE_SAMSUNG = 1;

  // Durations in T; 5 bits cover the longest (16T) leader.
  localparam logic [4:0] T_LEAD_NEC     = 5'd16;
  localparam logic [4:0] T_LEAD_SAMSUNG = 5'd8;
  localparam logic [4:0] T_LEAD_SPACE   = 5'd8;
  localparam logic [4:0] T_RPT_SPACE    = 5'd4;
  localparam logic [4:0] T_UNIT         = 5'd1;
  localparam logic [4:0] T_ONE_SPACE    = 5'd3;

  function automatic logic is_mark(ir_state_e s);
    return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// Single-bit key debouncer.
// A 2-FF synchroniser feeds a stability counter; the debounced level only
// follows the synchronised input after DEB_CYC consecutive cycles of
// disagreement. Resets to "released".
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   key_i   raw asynchronous key level
//   key_o   debounced key level
module ir_debounce #(
  parameter int unsigned DEB_CYC = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_o
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_o = stable_q;

endmodule

// File: rtl/ir_keypad_tx.sv
// Keypad-to-infrared transmitter.
// Debounces N_KEYS keys, picks the lowest-index held key, looks up its 32-bit
// code and sends it as an NEC (MODE=0) or Samsung (MODE=1) frame, modulated
// onto a carrier. While the key stays held the frame auto-repeats every
// FRAME_T units: NEC sends a short repeat code, Samsung resends the frame.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          transmit enable, looked at only when a frame would start
//   key         raw active-high keys
//   cmd_table   code for key i at bits [32i+31:32i]
//   ir_out      envelope AND carrier, drives the IR LED
//   ir_env      unmodulated envelope (1 = mark)
//   busy        high whenever the FSM is not idle
//   active_key  index of the key being sent
//   frame_done  one-cycle pulse at the end of each frame/repeat gap
module ir_keypad_tx
  import ir_pkg::*;
#(
  parameter int unsigned N_KEYS      = 2,
  parameter int unsigned MODE        = 1,
  parameter int unsigned TICK_CYC    = 14063,
  parameter int unsigned CARRIER_DIV = 658,
  parameter int unsigned DEB_CYC     = 250000,
  parameter int unsigned FRAME_T     = 192
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_KEYS-1:0]    key,
  input  logic [N_KEYS*32-1:0] cmd_table,
  output logic                 ir_out,
  output logic                 ir_env,
  output logic                 busy,
  output logic [3:0]           active_key,
  output logic                 frame_done
);

  localparam int unsigned TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned CW = $clog2(CARRIER_DIV);
  localparam int unsigned FW = (FRAME_T > 1) ? $clog2(FRAME_T) : 1;

  localparam logic [TW-1:0] TickLast  = TW'(TICK_CYC - 1);
  localparam logic [CW-1:0] CarLast   = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CarHalf   = CW'(CARRIER_DIV / 2);
  localparam logic [FW-1:0] FrameLast = FW'(FRAME_T - 1);

  // Debounced keys
  logic [N_KEYS-1:0] deb;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_deb
    ir_debounce #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .clk_i (clk),
      .rst_ni(rst_n),
      .key_i (key[gi]),
      .key_o (deb[gi])
    );
  end

  ir_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [4:0]    tcnt_q, tcnt_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] car_q, car_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   code_q, code_d;
  logic [3:0]    key_idx_q, key_idx_d;
  logic          rpt_q, rpt_d;
  logic          ir_env_q, ir_env_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  // Key selection: lowest-index debounced key wins.
  logic        any_key, held_same, found;
  logic [3:0]  sel_idx;
  logic [31:0] sel_code;

  always_comb begin
    any_key   = |deb;
    found     = 1'b0;
    sel_idx   = '0;
    sel_code  = '0;
    held_same = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (deb[i] && !found) begin
        found    = 1'b1;
        sel_idx  = 4'(i);
        sel_code = cmd_table[32*i +: 32];
      end
      if (deb[i] && (key_idx_q == 4'(i))) begin
        held_same = 1'b1;
      end
    end
  end

  // Unit timing: tick_q divides clk into T, tcnt_q counts T within a state.
  logic       tick_wrap, unit_done, bit_val;
  logic [4:0] dur;

  assign tick_wrap = (tick_q == TickLast);
  assign bit_val   = code_q[5'd31 - bit_idx_q];

  always_comb begin
    case (state_q)
      StLeadMark:  dur = (MODE == MODE_SAMSUNG) ? T_LEAD_SAMSUNG : T_LEAD_NEC;
      StLeadSpace: dur = T_LEAD_SPACE;
      StRptSpace:  dur = T_RPT_SPACE;
      StBitSpace:  dur = bit_val ? T_ONE_SPACE : T_UNIT;
      default:     dur = T_UNIT;
    endcase
  end

  assign unit_done = tick_wrap && (tcnt_q == dur - 5'd1);

  // Next-state logic
  logic gap_end, frame_start, entering;

  always_comb begin
    state_d     = state_q;
    gap_end     = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (en && any_key) begin
          state_d     = StLeadMark;
          frame_start = 1'b1;
        end
      end
      StLeadMark: begin
        if (unit_done) state_d = rpt_q ? StRptSpace : StLeadSpace;
      end
      StLeadSpace: begin
        if (unit_done) state_d = StBitMark;
      end
      StRptSpace: begin
        if (unit_done) state_d = StStopMark;
      end
      StBitMark: begin
        if (unit_done) state_d = StBitSpace;
      end
      StBitSpace: begin
        if (unit_done) state_d = (bit_idx_q == 5'd31) ? StStopMark : StBitMark;
      end
      StStopMark: begin
        if (unit_done) state_d = StGap;
      end
      StGap: begin
        // The gap is measured against the frame counter, not its own entry.
        if (tick_wrap && (frame_q == FrameLast)) begin
          gap_end = 1'b1;
          if (en && held_same) begin
            state_d     = StLeadMark;
            frame_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    entering = (state_d != state_q);

    tick_d  = (entering || tick_wrap) ? '0 : tick_q + TW'(1);
    tcnt_d  = entering ? '0 : (tick_wrap ? tcnt_q + 5'd1 : tcnt_q);
    frame_d = frame_start ? '0 : (tick_wrap ? frame_q + FW'(1) : frame_q);

    // Every mark starts on the high half of a carrier period.
    if ((entering && is_mark(state_d)) || (car_q == CarLast)) begin
      car_d = '0;
    end else begin
      car_d = car_q + CW'(1);
    end

    bit_idx_d = bit_idx_q;
    if (state_q == StLeadSpace) begin
      bit_idx_d = '0;
    end else if ((state_q == StBitSpace) && (state_d == StBitMark)) begin
      bit_idx_d = bit_idx_q + 5'd1;
    end

    // Code and index are frozen for the whole press; repeats reuse them.
    code_d    = code_q;
    key_idx_d = key_idx_q;
    rpt_d     = rpt_q;
    if (frame_start) begin
      rpt_d = (state_q == StGap) && (MODE == MODE_NEC);
      if (state_q == StIdle) begin
        code_d    = sel_code;
        key_idx_d = sel_idx;
      end
    end

    ir_env_d     = is_mark(state_d);
    busy_d       = (state_d != StIdle);
    frame_done_d = gap_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      tcnt_q       <= '0;
      frame_q      <= '0;
      car_q        <= '0;
      bit_idx_q    <= '0;
      code_q       <= '0;
      key_idx_q    <= '0;
      rpt_q        <= 1'b0;
      ir_env_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      tcnt_q       <= tcnt_d;
      frame_q      <= frame_d;
      car_q        <= car_d;
      bit_idx_q    <= bit_idx_d;
      code_q       <= code_d;
      key_idx_q    <= key_idx_d;
      rpt_q        <= rpt_d;
      ir_env_q     <= ir_env_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ir_env     = ir_env_q;
  assign ir_out     = ir_env_q & (car_q < CarHalf);
  assign busy       = busy_q;
  assign active_key = key_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ir_keypad_tx.sv
// Bench for ir_keypad_tx: an NEC and a Samsung instance share all stimulus.
// Expected waveforms come from a per-cycle timeline built from the protocol
// rules (segment lengths in T, bit 31 first, carrier phase per mark).
module tb_ir_keypad_tx;

  localparam int unsigned TICK = 4;
  localparam int unsigned CDIV = 2;
  localparam int unsigned DEB  = 3;
  localparam int unsigned FT   = 192;
  localparam int unsigned FLEN = TICK * FT;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [1:0]  key;
  logic [63:0] cmd_table;

  logic       ir_out_n, ir_env_n, busy_n, fd_n;
  logic [3:0] ak_n;
  logic       ir_out_s, ir_env_s, busy_s, fd_s;
  logic [3:0] ak_s;

  ir_keypad_tx #(
    .N_KEYS(2), .MODE(0), .TICK_CYC(TICK), .CARRIER_DIV(CDIV), .DEB_CYC(DEB), .FRAME_T(FT)
  ) dut_nec (
    .clk(clk), .rst_n(rst_n), .en(en), .key(key), .cmd_table(cmd_table),
    .ir_out(ir_out_n), .ir_env(ir_env_n), .busy(busy_n), .active_key(ak_n),
    .frame_done(fd_n)
  );

  ir_keypad_tx #(
    .N_KEYS(2), .MODE(1), .TICK_CYC(TICK), .CARRIER_DIV(CDIV), .DEB_CYC(DEB), .FRAME_T(FT)
  ) dut_sam (
    .clk(clk), .rst_n(rst_n), .en(en), .key(key), .cmd_table(cmd_table),
    .ir_out(ir_out_s), .ir_env(ir_env_s), .busy(busy_s), .active_key(ak_s),
    .frame_done(fd_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference timeline: index 0 = NEC instance, 1 = Samsung instance.
  bit env_m [2][FLEN];
  bit out_m [2][FLEN];
  int pos;

  task automatic seg(input int m, input int units, input bit mark);
    for (int k = 0; k < units * int'(TICK); k++) begin
      if (pos < int'(FLEN)) begin
        env_m[m][pos] = mark;
        out_m[m][pos] = mark && ((k % int'(CDIV)) < int'(CDIV / 2));
        pos++;
      end
    end
  endtask

  task automatic build(input int m, input logic [31:0] code, input bit samsung, input bit rpt);
    pos = 0;
    if (rpt) begin
      seg(m, 16, 1'b1);
      seg(m, 4, 1'b0);
      seg(m, 1, 1'b1);
    end else begin
      seg(m, samsung ? 8 : 16, 1'b1);
      seg(m, 8, 1'b0);
      for (int b = 31; b >= 0; b--) begin
        seg(m, 1, 1'b1);
        seg(m, code[b] ? 3 : 1, 1'b0);
      end
      seg(m, 1, 1'b1);
    end
    seg(m, FT, 1'b0);
  endtask

  // Check one frame starting at the current negedge (frame cycle 0). Returns
  // at the negedge of cycle FLEN, which is cycle 0 of any following frame.
  task automatic run_frame(input int f, input int frames, input logic [31:0] code,
                           input int exp_key, input int rel_cyc, input logic [1:0] rel_val,
                           input int en_drop, input string tag);
    int         bad [2];
    int         bad_c [2];
    logic [3:0] bad_a [2];
    logic [3:0] bad_e [2];
    logic [3:0] act, expv;
    build(0, code, 1'b0, f > 0);
    build(1, code, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      bad[m] = 0; bad_c[m] = 0; bad_a[m] = '0; bad_e[m] = '0;
    end
    for (int c = 0; c < int'(FLEN); c++) begin
      for (int m = 0; m < 2; m++) begin
        act  = (m == 0) ? {ir_env_n, ir_out_n, busy_n, fd_n} : {ir_env_s, ir_out_s, busy_s, fd_s};
        expv = {env_m[m][c], out_m[m][c], 1'b1, (c == 0) && (f > 0)};
        if (act !== expv) begin
          if (bad[m] == 0) begin
            bad_c[m] = c; bad_a[m] = act; bad_e[m] = expv;
          end
          bad[m]++;
        end
      end
      if (c == 0) begin
        chk({tag, " active_key nec"}, 32'(ak_n), 32'(exp_key));
        chk({tag, " active_key sam"}, 32'(ak_s), 32'(exp_key));
      end
      if ((f == frames - 1) && (c == rel_cyc)) key = rel_val;
      if ((f == 0) && (c == en_drop)) en = 1'b0;
      @(negedge clk);
    end
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (bad[m] != 0) begin
        n_errors++;
        $display("FAIL %s frame%0d dut%0d: %0d bad cycles, first at %0d got {env,out,busy,done}=%b expected %b",
                 tag, f, m, bad[m], bad_c[m], bad_a[m], bad_e[m]);
      end
    end
    chk({tag, " frame_done nec"}, 32'(fd_n), 32'd1);
    chk({tag, " frame_done sam"}, 32'(fd_s), 32'd1);
    chk({tag, " busy after gap nec"}, 32'(busy_n), 32'(f < frames - 1));
    chk({tag, " busy after gap sam"}, 32'(busy_s), 32'(f < frames - 1));
  endtask

  task automatic wait_busy(input string tag, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy_n || busy_s) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s start: got busy=0 after 12 cycles expected busy=1", tag);
    end
  endtask

  task automatic idle_check(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_n || busy_s) seen = 1'b1;
    end
    chk({tag, " stays idle"}, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  keys;
    logic [31:0] code0;
    logic [31:0] code1;
    int          frames;
    int          rel_cyc;
    int          en_drop;
    int          exp_key;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    cmd_table = {v.code1, v.code0};
    en        = 1'b1;
    key       = v.keys;
    wait_busy(tag, ok);
    if (ok) begin
      for (int f = 0; f < v.frames; f++) begin
        run_frame(f, v.frames, (v.exp_key == 0) ? v.code0 : v.code1, v.exp_key,
                  v.rel_cyc, 2'b00, v.en_drop, tag);
      end
    end
    key = 2'b00;
    repeat (10) @(negedge clk);
    en = 1'b1;
    idle_check(tag);
  endtask

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    bit ok;
    int cyc;
    bit found;

    vecs[0] = '{2'b01, 32'hE0E040BF, 32'h12345678, 1, 20, -1, 0};
    vecs[1] = '{2'b01, 32'hE0E040BF, 32'h12345678, 3, 700, -1, 0};
    vecs[2] = '{2'b01, 32'hE0E0C03F, 32'h0BADF00D, 3, 700, -1, 0};
    vecs[3] = '{2'b11, 32'hA5A50F0F, 32'hFFFF0000, 1, 20, -1, 0};
    vecs[4] = '{2'b10, 32'h11111111, 32'h00000001, 2, 650, -1, 1};
    vecs[5] = '{2'b01, 32'hFFFFFFFF, 32'h00000000, 1, -1, 300, 0};
    vecs[6] = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 1, 100, -1, 0};
    for (int i = 7; i < NV; i++) begin
      vecs[i].keys    = 2'($urandom_range(1, 3));
      vecs[i].code0   = $urandom;
      vecs[i].code1   = $urandom;
      vecs[i].frames  = $urandom_range(1, 2);
      vecs[i].rel_cyc = $urandom_range(10, 700);
      vecs[i].en_drop = -1;
      vecs[i].exp_key = vecs[i].keys[0] ? 0 : 1;
    end

    // Reset with a key already pressed
    rst_n     = 1'b0;
    en        = 1'b1;
    key       = 2'b01;
    cmd_table = {32'h1234ABCD, 32'hE0E040BF};
    repeat (3) @(negedge clk);
    chk("reset outs nec", 32'({ir_out_n, ir_env_n, busy_n, fd_n}), 32'd0);
    chk("reset outs sam", 32'({ir_out_s, ir_env_s, busy_s, fd_s}), 32'd0);
    chk("reset active_key", 32'({ak_n, ak_s}), 32'd0);
    rst_n = 1'b1;
    found = 1'b0;
    cyc   = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy_n && busy_s) begin
        found = 1'b1;
        cyc   = k;
        break;
      end
    end
    n_checks++;
    if (!found || cyc > 6) begin
      n_errors++;
      $display("FAIL reset_to_busy: got busy after %0d cycles (seen=%0d) expected within 6",
               cyc, found);
    end
    if (found) begin
      // Reset in the middle of a bit mark drops the output without a clock edge.
      build(0, 32'hE0E040BF, 1'b0, 1'b0);
      build(1, 32'hE0E040BF, 1'b1, 1'b0);
      repeat (96) @(negedge clk);
      chk("mid-bit env nec", 32'(ir_env_n), 32'(env_m[0][96]));
      chk("mid-bit out nec", 32'(ir_out_n), 32'(out_m[0][96]));
      chk("mid-bit env sam", 32'(ir_env_s), 32'(env_m[1][96]));
      chk("mid-bit out sam", 32'(ir_out_s), 32'(out_m[1][96]));
      #2 rst_n = 1'b0;
      #1;
      chk("async reset nec", 32'({ir_out_n, ir_env_n, busy_n}), 32'd0);
      chk("async reset sam", 32'({ir_out_s, ir_env_s, busy_s}), 32'd0);
    end
    key = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 2-cycle glitch on key[1] must not start a frame
    key = 2'b10;
    repeat (2) @(negedge clk);
    key = 2'b00;
    idle_check("glitch");

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Different key held at gap end: idle for one cycle, then key 1 starts.
    cmd_table = {32'h1234ABCD, 32'hE0E040BF};
    key       = 2'b01;
    en        = 1'b1;
    wait_busy("diffkey", ok);
    if (ok) begin
      run_frame(0, 1, 32'hE0E040BF, 0, 400, 2'b10, -1, "diffkey");
      @(negedge clk);
      chk("diffkey restart busy nec", 32'(busy_n), 32'd1);
      chk("diffkey restart key nec", 32'(ak_n), 32'd1);
      chk("diffkey restart busy sam", 32'(busy_s), 32'd1);
      chk("diffkey restart key sam", 32'(ak_s), 32'd1);
    end
    key   = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check("after diffkey");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no summary by time limit expected normal finish");
    $fatal(1, "time limit");
  end

endmodule
